// File: rtl/gated_edge_counter.sv
// gated_edge_counter
// Counts the one-cycle pulses coming out of the edge identifier over a gate
// window of N clock cycles. Each finished window produces its count with a
// one-cycle valid strobe and an overflow flag. In continuous mode the next
// window opens on the same edge that closes the current one, so there is no
// dead time between windows.
module gated_edge_counter #(
  parameter int W_CNT  = 32,
  parameter int W_GATE = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pls,
  input  logic [W_GATE-1:0] gate_len,
  input  logic              cont,
  input  logic              start,
  input  logic              stop,
  output logic [W_CNT-1:0]  cnt_out,
  output logic              cnt_vld,
  output logic              ovf,
  output logic              busy
);

  localparam logic [W_CNT-1:0]  CNT_ONE  = {{(W_CNT-1){1'b0}}, 1'b1};
  localparam logic [W_GATE-1:0] GATE_ONE = {{(W_GATE-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  // Window-local state: running count, overflow bit, remaining samples and
  // the mode bit captured when the window opened.
  logic [W_CNT-1:0]  acc;
  logic [W_CNT-1:0]  acc_nxt;
  logic              win_ovf;
  logic              win_ovf_nxt;
  logic [W_GATE-1:0] timer;
  logic [W_GATE-1:0] timer_nxt;
  logic              cont_q;
  logic              cont_q_nxt;

  // Published result of the last completed window.
  logic [W_CNT-1:0]  cnt_out_nxt;
  logic              ovf_nxt;
  logic              cnt_vld_nxt;

  // Helper terms.
  logic              acc_full;
  logic [W_CNT-1:0]  acc_inc;
  logic              win_ovf_inc;
  logic              gate_nonzero;
  logic              start_ok;
  logic              last_sample;

  // The accumulator sticks at all-ones; a pulse that arrives while it is
  // already full is what marks the window as overflowed.
  assign acc_full     = &acc;
  assign acc_inc      = (pls && !acc_full) ? (acc + CNT_ONE) : acc;
  assign win_ovf_inc  = win_ovf | (pls & acc_full);
  assign gate_nonzero = (gate_len != '0);

  // Stop has priority over start, and a zero-length window is meaningless.
  assign start_ok     = start && !stop && gate_nonzero;

  // The timer holds the number of samples still to take, including the one
  // at this edge, so a value of 1 means this edge is the last sample.
  assign last_sample  = (timer == GATE_ONE);

  assign busy = (state == COUNT);

  // Next-state and datapath decode: everything holds unless a rule below
  // says otherwise; the valid strobe defaults low so it lasts one cycle.
  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    win_ovf_nxt = win_ovf;
    timer_nxt   = timer;
    cont_q_nxt  = cont_q;
    cnt_out_nxt = cnt_out;
    ovf_nxt     = ovf;
    cnt_vld_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (start_ok) begin
          state_nxt   = COUNT;
          timer_nxt   = gate_len;
          cont_q_nxt  = cont;
          acc_nxt     = '0;
          win_ovf_nxt = 1'b0;
        end
      end

      COUNT: begin
        if (stop) begin
          // Abort: the partial count is dropped and the old result stays.
          state_nxt   = IDLE;
          acc_nxt     = '0;
          win_ovf_nxt = 1'b0;
          timer_nxt   = '0;
        end else if (last_sample) begin
          // The sample at this edge still belongs to the closing window.
          cnt_out_nxt = acc_inc;
          ovf_nxt     = win_ovf_inc;
          cnt_vld_nxt = 1'b1;
          acc_nxt     = '0;
          win_ovf_nxt = 1'b0;
          if (cont_q && gate_nonzero) begin
            // Reopen immediately so the very next edge is the first sample
            // of the new window.
            timer_nxt  = gate_len;
            cont_q_nxt = cont;
          end else begin
            state_nxt = IDLE;
            timer_nxt = '0;
          end
        end else begin
          acc_nxt     = acc_inc;
          win_ovf_nxt = win_ovf_inc;
          timer_nxt   = timer - GATE_ONE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath and result registers; reset drops any open window silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      win_ovf <= 1'b0;
      timer   <= '0;
      cont_q  <= 1'b0;
      cnt_out <= '0;
      ovf     <= 1'b0;
      cnt_vld <= 1'b0;
    end else begin
      acc     <= acc_nxt;
      win_ovf <= win_ovf_nxt;
      timer   <= timer_nxt;
      cont_q  <= cont_q_nxt;
      cnt_out <= cnt_out_nxt;
      ovf     <= ovf_nxt;
      cnt_vld <= cnt_vld_nxt;
    end
  end

endmodule

// File: tb/tb_gated_edge_counter.sv
// tb_gated_edge_counter
// Directed scenarios followed by random traffic. A window-level reference
// model (pulse total as a plain integer, clamped only when the result is
// published) predicts every output each cycle.
module tb_gated_edge_counter;

  localparam int W_CNT   = 4;
  localparam int W_GATE  = 8;
  localparam int CNT_MAX = (1 << W_CNT) - 1;

  logic              clk;
  logic              rst_n;
  logic              pls;
  logic [W_GATE-1:0] gate_len;
  logic              cont;
  logic              start;
  logic              stop;
  logic [W_CNT-1:0]  cnt_out;
  logic              cnt_vld;
  logic              ovf;
  logic              busy;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  bit m_active;
  int m_remaining;
  int m_total;
  bit m_cont;
  int m_out;
  bit m_ovf;
  bit m_vld;

  gated_edge_counter #(
    .W_CNT (W_CNT),
    .W_GATE(W_GATE)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pls     (pls),
    .gate_len(gate_len),
    .cont    (cont),
    .start   (start),
    .stop    (stop),
    .cnt_out (cnt_out),
    .cnt_vld (cnt_vld),
    .ovf     (ovf),
    .busy    (busy)
  );

  // 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at t=%0t",
               tag, observed, expected, $time);
    end
  endtask

  // Drive one sample's worth of inputs, then wait past the edge that takes it.
  task automatic applyStimulus(input logic s, input logic st, input logic p,
                               input logic c, input logic [W_GATE-1:0] len);
    start    = s;
    stop     = st;
    pls      = p;
    cont     = c;
    gate_len = len;
    @(negedge clk);
  endtask

  // Window-level model: a window is just "take the next N samples and add
  // them up"; the published count is the total clamped to the counter range.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active    = 1'b0;
      m_remaining = 0;
      m_total     = 0;
      m_cont      = 1'b0;
      m_out       = 0;
      m_ovf       = 1'b0;
      m_vld       = 1'b0;
    end else begin
      m_vld = 1'b0;
      if (!m_active) begin
        if (start && !stop && gate_len != 0) begin
          m_active    = 1'b1;
          m_remaining = int'(gate_len);
          m_total     = 0;
          m_cont      = cont;
        end
      end else if (stop) begin
        m_active = 1'b0;
      end else begin
        m_total     = m_total + int'(pls);
        m_remaining = m_remaining - 1;
        if (m_remaining == 0) begin
          m_out = (m_total > CNT_MAX) ? CNT_MAX : m_total;
          m_ovf = (m_total > CNT_MAX);
          m_vld = 1'b1;
          if (m_cont && gate_len != 0) begin
            m_remaining = int'(gate_len);
            m_total     = 0;
            m_cont      = cont;
          end else begin
            m_active = 1'b0;
          end
        end
      end
    end
  end

  // Every cycle, away from the rising edge, outputs must match the model.
  always @(negedge clk) begin
    checkOutput("model_cnt_out", 32'(cnt_out), 32'(m_out));
    checkOutput("model_cnt_vld", 32'(cnt_vld), 32'(m_vld));
    checkOutput("model_ovf", 32'(ovf), 32'(m_ovf));
    checkOutput("model_busy", 32'(busy), 32'(m_active));
  end

  initial begin
    start    = 1'b0;
    stop     = 1'b0;
    pls      = 1'b0;
    cont     = 1'b0;
    gate_len = '0;
    rst_n    = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("reset_cnt_out", 32'(cnt_out), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-shot, N=10, pulse on the start edge plus samples 1, 4, 10.
    $display("[TB] single-shot window");
    applyStimulus(1, 0, 1, 0, 8'd10);
    for (int j = 1; j <= 10; j++) begin
      applyStimulus(0, 0, (j == 1 || j == 4 || j == 10), 0, 8'd10);
      if (j < 10) checkOutput("ss_no_early_vld", 32'(cnt_vld), 0);
    end
    checkOutput("ss_vld", 32'(cnt_vld), 1);
    checkOutput("ss_cnt", 32'(cnt_out), 3);
    checkOutput("ss_ovf", 32'(ovf), 0);
    checkOutput("ss_busy", 32'(busy), 0);
    applyStimulus(0, 0, 0, 0, 8'd10);
    checkOutput("ss_vld_one_cycle", 32'(cnt_vld), 0);

    // Continuous, N=4, pls held high; cont dropped for the third window.
    $display("[TB] continuous windows");
    applyStimulus(1, 0, 1, 1, 8'd4);
    for (int j = 1; j <= 12; j++) begin
      applyStimulus(0, 0, 1, (j < 8), 8'd4);
      checkOutput("cont_vld_spacing", 32'(cnt_vld), 32'((j % 4) == 0));
      if ((j % 4) == 0) checkOutput("cont_cnt", 32'(cnt_out), 4);
    end
    checkOutput("cont_busy_end", 32'(busy), 0);

    // Saturation: 20 pulses into a 4-bit counter, then a clean window.
    $display("[TB] saturation");
    applyStimulus(1, 0, 1, 0, 8'd20);
    for (int j = 1; j <= 20; j++) applyStimulus(0, 0, 1, 0, 8'd20);
    checkOutput("sat_cnt", 32'(cnt_out), 15);
    checkOutput("sat_ovf", 32'(ovf), 1);
    applyStimulus(1, 0, 0, 0, 8'd5);
    for (int j = 1; j <= 5; j++) applyStimulus(0, 0, (j == 2 || j == 5), 0, 8'd5);
    checkOutput("post_sat_cnt", 32'(cnt_out), 2);
    checkOutput("post_sat_ovf", 32'(ovf), 0);

    // Abort: establish a result of 3, then stop at sample 5 of 10.
    $display("[TB] abort");
    applyStimulus(1, 0, 0, 0, 8'd3);
    for (int j = 1; j <= 3; j++) applyStimulus(0, 0, 1, 0, 8'd3);
    checkOutput("pre_abort_cnt", 32'(cnt_out), 3);
    applyStimulus(1, 0, 0, 0, 8'd10);
    for (int j = 1; j <= 5; j++) applyStimulus(0, (j == 5), 1, 0, 8'd10);
    checkOutput("abort_busy", 32'(busy), 0);
    for (int j = 0; j < 8; j++) begin
      applyStimulus(0, 0, 1, 0, 8'd10);
      checkOutput("abort_no_vld", 32'(cnt_vld), 0);
    end
    checkOutput("abort_cnt_kept", 32'(cnt_out), 3);
    applyStimulus(1, 1, 0, 0, 8'd5);
    checkOutput("start_stop_busy", 32'(busy), 0);
    applyStimulus(0, 0, 0, 0, 8'd5);
    checkOutput("start_stop_busy2", 32'(busy), 0);

    // Rejection of a zero-length window, then reset in mid-window.
    $display("[TB] rejection and reset");
    applyStimulus(1, 0, 1, 0, 8'd0);
    checkOutput("zero_len_busy", 32'(busy), 0);
    applyStimulus(1, 0, 1, 1, 8'd10);
    for (int j = 1; j <= 3; j++) applyStimulus(0, 0, 1, 1, 8'd10);
    checkOutput("pre_reset_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_cnt", 32'(cnt_out), 0);
    checkOutput("rst_async_busy", 32'(busy), 0);
    checkOutput("rst_async_vld", 32'(cnt_vld), 0);
    checkOutput("rst_async_ovf", 32'(ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 12; j++) begin
      applyStimulus(0, 0, 1, 1, 8'd10);
      checkOutput("rst_no_vld", 32'(cnt_vld), 0);
    end

    // Continuous reload: 4 -> 6 mid-window, then cont dropped.
    $display("[TB] continuous reload");
    applyStimulus(1, 0, 0, 1, 8'd4);
    for (int j = 1; j <= 16; j++) begin
      applyStimulus(0, 0, 1'($urandom_range(0, 1)), (j < 6), (j >= 2) ? 8'd6 : 8'd4);
      checkOutput("reload_vld", 32'(cnt_vld), 32'(j == 4 || j == 10 || j == 16));
    end
    checkOutput("reload_busy_end", 32'(busy), 0);

    // Random traffic, including N=1 continuous runs.
    $display("[TB] random traffic");
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 39) == 0),
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 3) != 0),
                    W_GATE'($urandom_range(0, 6)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
